// File: rtl/bambu_memarb_pkg.sv
// Shared types for the two-channel memory arbiter: FSM states, op kinds and
// the latency counter width.
package bambu_memarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } memarb_state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } memarb_op_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/memarb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to rr_ptr.
module memarb_rr_pick (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = (req == 2'b11) ? rr_ptr : req[1];
  end

endmodule

// File: rtl/bambu_mem_arbiter.sv
// Two-channel arbiter onto one shared synchronous memory port, one access in
// flight at a time. Define MEMARB_PROT_CHECK_EN to flag oe&we as a protocol error.
module bambu_mem_arbiter
  import bambu_memarb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SIZE_W   = 4,
  parameter int unsigned RD_DELAY = 2,
  parameter int unsigned WR_DELAY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          m_oe,
  input  logic [1:0]          m_we,
  input  logic [2*ADDR_W-1:0] m_addr,
  input  logic [2*DATA_W-1:0] m_wdata,
  input  logic [2*SIZE_W-1:0] m_size,
  output logic [2*DATA_W-1:0] m_rdata,
  output logic [1:0]          m_datardy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_mask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_DELAY - 1);

  memarb_state_e r_state, w_state_nxt;
  memarb_op_e    r_op, w_gnt_op;

  logic                     r_rr_ptr;
  logic                     r_gnt;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_wdata;
  logic [SIZE_W-1:0]        r_size;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_load;
  logic                     r_first;
  logic [DATA_W-1:0]        r_cap;
  logic [1:0][DATA_W-1:0]   r_hold;
  logic [1:0][DATA_W-1:0]   w_rdata;
  logic [DATA_W-1:0]        w_mask;
  logic [1:0]               w_req;
  logic                     w_gnt_valid;
  logic                     w_gnt_idx;

`ifdef MEMARB_PROT_CHECK_EN
  logic [1:0] w_bad;
  logic       r_err;

  // A channel asserting both oe and we is dropped from arbitration.
  assign w_bad = m_oe & m_we;
  assign w_req = (m_oe | m_we) & ~w_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             r_err <= 1'b0;
    else if (r_state == IDLE && |w_bad)    r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_req = m_oe | m_we;
  assign err   = 1'b0;
`endif

  memarb_rr_pick u_pick (
    .req       (w_req),
    .rr_ptr    (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // oe wins over we, so an unchecked oe&we request is served as a read.
  assign w_gnt_op = m_oe[w_gnt_idx] ? RD : WR;
  assign w_load   = (r_op == RD) ? RD_LOAD : WR_LOAD;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = (w_load == '0) ? RESP : WAIT;
      WAIT:    if (r_cnt == CNT_W'(1)) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= 1'b0;
      r_gnt    <= 1'b0;
      r_op     <= RD;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_size   <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b0;
      r_cap    <= '0;
      r_hold   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_valid) begin
          r_gnt   <= w_gnt_idx;
          r_op    <= w_gnt_op;
          r_addr  <= w_gnt_idx ? m_addr[2*ADDR_W-1:ADDR_W]  : m_addr[ADDR_W-1:0];
          r_wdata <= w_gnt_idx ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
          r_size  <= w_gnt_idx ? m_size[2*SIZE_W-1:SIZE_W]  : m_size[SIZE_W-1:0];
        end
        ISSUE: begin
          r_cnt   <= w_load;
          r_first <= 1'b1;
        end
        WAIT: begin
          r_cnt   <= r_cnt - CNT_W'(1);
          r_first <= 1'b0;
          // Memory read data is only valid the cycle after mem_en.
          if (r_first && r_op == RD) r_cap <= mem_rdata;
        end
        RESP: begin
          r_hold   <= w_rdata;
          r_rr_ptr <= ~r_gnt;
        end
        default: ;
      endcase
    end
  end

  // Bit i enabled when i < size: covers size 0 and saturates at DATA_W.
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < DATA_W; i++) w_mask[i] = (32'(r_size) > i);
  end

  always_comb begin
    w_rdata = r_hold;
    if (r_state == RESP) begin
      w_rdata        = '0;
      w_rdata[r_gnt] = (r_op == RD) ? r_cap : r_hold[r_gnt];
    end
  end

  always_comb begin
    mem_en    = (r_state == ISSUE);
    mem_we    = mem_en && (r_op == WR);
    mem_addr  = mem_en ? r_addr  : '0;
    mem_wdata = mem_en ? r_wdata : '0;
    mem_mask  = mem_en ? w_mask  : '0;
    m_datardy = (r_state == RESP) ? (2'b01 << r_gnt) : 2'b00;
    m_rdata   = w_rdata;
  end

endmodule
